vga_frame_commit: RTL and testbench

- Frame-synchronous commit controller placed between the game FSM and the VGA video generator.
- Holds shadow copies of the 5x5 board matrices, cursor matrices and win/lose flags that feed the video generator.
- Updates those copies only at the start of vertical sync, using a four-phase req/ack handshake, so a frame never shows a half-updated board.
- Also keeps a frame counter and a cursor-blink phase.

---
 rtl/vga_frame_commit.sv | 159 +++++++++++++++
 tb/tb_vga_frame_commit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_commit.sv
// Frame-synchronous commit of staged board/cursor/flag data into the VGA shadow registers.
// Defining CURSOR_BLINK_EN builds the blink counter that gates the cursor outputs.
module vga_frame_commit #(
    parameter int BLINK_FRAMES = 15,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vsync,
    input  logic                   update_req,
    input  logic [4:0][4:0][1:0]   matriz_barcos_in,
    input  logic [4:0][4:0][1:0]   matriz_golpes_in,
    input  logic [4:0][4:0][1:0]   matriz_disparos_in,
    input  logic [4:0][4:0][1:0]   matriz_posicion_jugador_colocar_in,
    input  logic [4:0][4:0][1:0]   matriz_posicion_jugador_atacar_in,
    input  logic                   display_win_in,
    input  logic                   display_lose_in,
    output logic                   update_ack,
    output logic                   busy,
    output logic [4:0][4:0][1:0]   matriz_barcos,
    output logic [4:0][4:0][1:0]   matriz_golpes,
    output logic [4:0][4:0][1:0]   matriz_disparos,
    output logic [4:0][4:0][1:0]   matriz_posicion_jugador_colocar,
    output logic [4:0][4:0][1:0]   matriz_posicion_jugador_atacar,
    output logic                   display_win,
    output logic                   display_lose,
    output logic [FRAME_CNT_W-1:0] frame_count
);
    typedef enum logic [1:0] {IDLE, PENDING, COMMIT, ACK} state_t;

    state_t                 state_q;
    logic                   reqMeta_q;
    logic                   reqSync_q;
    logic                   vsync_q;
    logic                   frameTick;
    logic [FRAME_CNT_W-1:0] frameCount_q;
    logic [FRAME_CNT_W-1:0] frameCount_d;
    logic [4:0][4:0][1:0]   barcos_q;
    logic [4:0][4:0][1:0]   golpes_q;
    logic [4:0][4:0][1:0]   disparos_q;
    logic [4:0][4:0][1:0]   colocar_q;
    logic [4:0][4:0][1:0]   atacar_q;
    logic                   win_q;
    logic                   lose_q;
    logic                   ack_q;
    logic                   busy_q;

    assign frameTick    = vsync_q & ~vsync;
    assign frameCount_d = frameTick ? frameCount_q + 1'b1 : frameCount_q;

    // update_req comes from the game clock domain, so it is double-flopped before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqMeta_q    <= 1'b0;
            reqSync_q    <= 1'b0;
            vsync_q      <= 1'b1;
            frameCount_q <= '0;
        end else begin
            reqMeta_q    <= update_req;
            reqSync_q    <= reqMeta_q;
            vsync_q      <= vsync;
            frameCount_q <= frameCount_d;
        end
    end

    // Shadows load on the edge entering COMMIT, so they are visible during the one COMMIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            barcos_q   <= '0;
            golpes_q   <= '0;
            disparos_q <= '0;
            colocar_q  <= '0;
            atacar_q   <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqSync_q) begin
                        state_q <= PENDING;
                        busy_q  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (!reqSync_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (frameTick) begin
                        state_q    <= COMMIT;
                        barcos_q   <= matriz_barcos_in;
                        golpes_q   <= matriz_golpes_in;
                        disparos_q <= matriz_disparos_in;
                        colocar_q  <= matriz_posicion_jugador_colocar_in;
                        atacar_q   <= matriz_posicion_jugador_atacar_in;
                        win_q      <= display_win_in & ~display_lose_in;
                        lose_q     <= display_lose_in;
                    end
                end
                COMMIT: begin
                    state_q <= ACK;
                    ack_q   <= 1'b1;
                end
                ACK: begin
                    if (!reqSync_q) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign update_ack      = ack_q;
    assign busy            = busy_q;
    assign matriz_barcos   = barcos_q;
    assign matriz_golpes   = golpes_q;
    assign matriz_disparos = disparos_q;
    assign display_win     = win_q;
    assign display_lose    = lose_q;
    assign frame_count     = frameCount_q;

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_W-1:0] blinkCnt_q;
    logic               blinkPhase_q;

    // Phase starts visible and flips each time the counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b1;
        end else if (frameTick) begin
            if (blinkCnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blinkCnt_q   <= '0;
                blinkPhase_q <= ~blinkPhase_q;
            end else begin
                blinkCnt_q <= blinkCnt_q + 1'b1;
            end
        end
    end

    assign matriz_posicion_jugador_colocar = blinkPhase_q ? colocar_q : '0;
    assign matriz_posicion_jugador_atacar  = blinkPhase_q ? atacar_q  : '0;
`else
    assign matriz_posicion_jugador_colocar = colocar_q;
    assign matriz_posicion_jugador_atacar  = atacar_q;
`endif

endmodule

// File: tb/tb_vga_frame_commit.sv
// Self-checking bench for vga_frame_commit: randomized commits checked against a frame-level model.
// Blink expectations follow CURSOR_BLINK_EN when it is defined for the build.
module tb_vga_frame_commit;
    localparam int BLINK = 2;
    localparam int CW    = 4;

    typedef logic [4:0][4:0][1:0] board_t;

    logic          clk;
    logic          rst;
    logic          vsync;
    logic          update_req;
    board_t        barcosIn, golpesIn, disparosIn, colocarIn, atacarIn;
    logic          winIn, loseIn;
    logic          update_ack, busy, display_win, display_lose;
    board_t        barcos, golpes, disparos, colocar, atacar;
    logic [CW-1:0] frame_count;

    board_t expB, expG, expD, expC, expA;
    logic   expWin, expLose;
    int     ticks;
    int     errors = 0;
    int     checks = 0;

    vga_frame_commit #(.BLINK_FRAMES(BLINK), .FRAME_CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .vsync(vsync),
        .update_req(update_req),
        .matriz_barcos_in(barcosIn),
        .matriz_golpes_in(golpesIn),
        .matriz_disparos_in(disparosIn),
        .matriz_posicion_jugador_colocar_in(colocarIn),
        .matriz_posicion_jugador_atacar_in(atacarIn),
        .display_win_in(winIn),
        .display_lose_in(loseIn),
        .update_ack(update_ack),
        .busy(busy),
        .matriz_barcos(barcos),
        .matriz_golpes(golpes),
        .matriz_disparos(disparos),
        .matriz_posicion_jugador_colocar(colocar),
        .matriz_posicion_jugador_atacar(atacar),
        .display_win(display_win),
        .display_lose(display_lose),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Cursor is shown during the first BLINK frames after reset, hidden for the next BLINK, and so on.
    function automatic board_t cursorView(input board_t s, input int t);
`ifdef CURSOR_BLINK_EN
        return (((t / BLINK) % 2) == 0) ? s : '0;
`else
        return s;
`endif
    endfunction

    task automatic commitModel();
        expB    = barcosIn;
        expG    = golpesIn;
        expD    = disparosIn;
        expC    = colocarIn;
        expA    = atacarIn;
        expLose = loseIn;
        expWin  = winIn && !loseIn;
    endtask

    task automatic clearModel();
        expB = '0; expG = '0; expD = '0; expC = '0; expA = '0;
        expWin = 1'b0; expLose = 1'b0; ticks = 0;
    endtask

    task automatic randomizeInputs();
        logic [63:0] r;
        r = {$urandom, $urandom}; barcosIn   = r[49:0];
        r = {$urandom, $urandom}; golpesIn   = r[49:0];
        r = {$urandom, $urandom}; disparosIn = r[49:0];
        r = {$urandom, $urandom}; colocarIn  = r[49:0];
        r = {$urandom, $urandom}; atacarIn   = r[49:0];
        winIn  = r[50];
        loseIn = r[51];
    endtask

    task automatic pulseVsync();
        @(posedge clk); #1 vsync = 1'b0;
        @(posedge clk); ticks++; #1 vsync = 1'b1;
    endtask

    task automatic raiseReq();
        @(posedge clk); #1 update_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic dropReq();
        @(posedge clk); #1 update_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fullCommit(output bit timedOut);
        int n;
        raiseReq();
        pulseVsync();
        commitModel();
        n = 0;
        while (update_ack !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        timedOut = (update_ack !== 1'b1);
        dropReq();
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; update_req = 1'b0;
        barcosIn = '0; golpesIn = '0; disparosIn = '0; colocarIn = '0; atacarIn = '0;
        winIn = 1'b0; loseIn = 1'b0;
        clearModel();
        #2;
        checks++;
        if ({update_ack, busy, display_win, display_lose} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {update_ack, busy, display_win, display_lose});
        end
        checks++;
        if ({barcos, golpes, disparos, colocar, atacar} !== '0 || frame_count !== '0) begin
            errors++; $display("[TB] FAIL reset_data: got barcos=%h count=%0d expected all zero", barcos, frame_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic_commit();
        randomizeInputs();
        barcosIn[2][3] = 2'b01;
        colocarIn[1][1] = 2'b11;
        raiseReq();
        checks++;
        if (busy !== 1'b1 || update_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_pending: got busy=%b ack=%b expected busy=1 ack=0", busy, update_ack);
        end
        checks++;
        if (barcos !== expB) begin
            errors++; $display("[TB] FAIL basic_hold: got %h expected %h", barcos, expB);
        end
        pulseVsync();
        commitModel();
        @(negedge clk);
        checks++;
        if (barcos[2][3] !== 2'b01 || {barcos, golpes, disparos} !== {expB, expG, expD}) begin
            errors++; $display("[TB] FAIL basic_shadow: got cell=%b barcos=%h expected cell=01 barcos=%h", barcos[2][3], barcos, expB);
        end
        checks++;
        if (update_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_ack_early: got %b expected 0", update_ack);
        end
        @(negedge clk);
        checks++;
        if (update_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_ack_rise: got %b expected 1", update_ack);
        end
        checks++;
        if (frame_count !== CW'(ticks % (1 << CW)) || colocar !== cursorView(expC, ticks)) begin
            errors++; $display("[TB] FAIL basic_count_cursor: got count=%0d colocar=%h expected count=%0d colocar=%h",
                               frame_count, colocar, ticks % (1 << CW), cursorView(expC, ticks));
        end
        @(posedge clk); #1 update_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (update_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_ack_hold: got %b expected 1", update_ack);
        end
        @(negedge clk);
        checks++;
        if (update_ack !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_ack_drop: got ack=%b busy=%b expected 0 0", update_ack, busy);
        end
    endtask

    task automatic test_abort();
        bit sawAck;
        randomizeInputs();
        raiseReq();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_pending: got busy=%b expected 1", busy);
        end
        @(posedge clk); #1 update_req = 1'b0;
        sawAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (update_ack !== 1'b0) sawAck = 1'b1;
        end
        checks++;
        if (sawAck || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_idle: got sawAck=%b busy=%b expected 0 0", sawAck, busy);
        end
        pulseVsync();
        @(negedge clk);
        checks++;
        if ({barcos, golpes, disparos, display_win, display_lose} !== {expB, expG, expD, expWin, expLose}) begin
            errors++; $display("[TB] FAIL abort_shadow: got barcos=%h expected %h", barcos, expB);
        end
        checks++;
        if (frame_count !== CW'(ticks % (1 << CW)) || update_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_count: got count=%0d ack=%b expected count=%0d ack=0", frame_count, update_ack, ticks % (1 << CW));
        end
    endtask

    task automatic test_same_cycle_tick();
        int n;
        randomizeInputs();
        @(posedge clk); #1 update_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 vsync = 1'b0;
        @(posedge clk); ticks++; #1 vsync = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || update_ack !== 1'b0 || barcos !== expB || atacar !== cursorView(expA, ticks)) begin
            errors++; $display("[TB] FAIL same_tick_wait: got busy=%b ack=%b barcos=%h expected busy=1 ack=0 barcos=%h",
                               busy, update_ack, barcos, expB);
        end
        pulseVsync();
        commitModel();
        @(negedge clk);
        checks++;
        if ({barcos, golpes, disparos} !== {expB, expG, expD}) begin
            errors++; $display("[TB] FAIL same_tick_commit: got barcos=%h expected %h", barcos, expB);
        end
        n = 0;
        while (update_ack !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (update_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL same_tick_ack: got %b expected 1 within 8 cycles", update_ack);
        end
        dropReq();
    endtask

    task automatic test_flag_conflict();
        bit timedOut;
        randomizeInputs();
        winIn = 1'b1; loseIn = 1'b1;
        fullCommit(timedOut);
        checks++;
        if (timedOut || display_lose !== 1'b1 || display_win !== 1'b0) begin
            errors++; $display("[TB] FAIL flag_conflict: got timeout=%b win=%b lose=%b expected 0 0 1", timedOut, display_win, display_lose);
        end
        randomizeInputs();
        winIn = 1'b1; loseIn = 1'b0;
        fullCommit(timedOut);
        checks++;
        if (timedOut || display_lose !== 1'b0 || display_win !== 1'b1) begin
            errors++; $display("[TB] FAIL flag_win: got timeout=%b win=%b lose=%b expected 0 1 0", timedOut, display_win, display_lose);
        end
    endtask

    task automatic test_random_commits();
        bit timedOut;
        int gap;
        for (int k = 0; k < 6; k++) begin
            randomizeInputs();
            fullCommit(timedOut);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) pulseVsync();
            @(negedge clk);
            checks++;
            if (timedOut || {barcos, golpes, disparos, display_win, display_lose} !== {expB, expG, expD, expWin, expLose}) begin
                errors++; $display("[TB] FAIL rand_board_%0d: got timeout=%b barcos=%h win=%b lose=%b expected barcos=%h win=%b lose=%b",
                                   k, timedOut, barcos, display_win, display_lose, expB, expWin, expLose);
            end
            checks++;
            if (colocar !== cursorView(expC, ticks) || atacar !== cursorView(expA, ticks) || frame_count !== CW'(ticks % (1 << CW))) begin
                errors++; $display("[TB] FAIL rand_cursor_%0d: got colocar=%h count=%0d expected colocar=%h count=%0d",
                                   k, colocar, frame_count, cursorView(expC, ticks), ticks % (1 << CW));
            end
        end
    endtask

    task automatic test_blink_and_wrap();
        bit timedOut;
        randomizeInputs();
        colocarIn = '1;
        fullCommit(timedOut);
        checks++;
        if (timedOut) begin
            errors++; $display("[TB] FAIL blink_setup: got ack timeout expected ack");
        end
        for (int f = 0; f < 18; f++) begin
            pulseVsync();
            @(negedge clk);
            checks++;
            if (frame_count !== CW'(ticks % (1 << CW)) || colocar[0][0] !== cursorView(expC, ticks)[0][0]) begin
                errors++; $display("[TB] FAIL blink_frame_%0d: got count=%0d cell=%b expected count=%0d cell=%b",
                                   f, frame_count, colocar[0][0], ticks % (1 << CW), cursorView(expC, ticks)[0][0]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit timedOut;
        int n;
        randomizeInputs();
        raiseReq();
        pulseVsync();
        commitModel();
        n = 0;
        while (update_ack !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk); #2 rst = 1'b1;
        #1;
        checks++;
        if ({update_ack, busy, display_win, display_lose} !== 4'b0000 || frame_count !== '0) begin
            errors++; $display("[TB] FAIL async_reset_ctrl: got ack=%b busy=%b count=%0d expected 0 0 0", update_ack, busy, frame_count);
        end
        checks++;
        if ({barcos, golpes, disparos, colocar, atacar} !== '0) begin
            errors++; $display("[TB] FAIL async_reset_data: got barcos=%h colocar=%h expected 0", barcos, colocar);
        end
        clearModel();
        update_req = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        randomizeInputs();
        fullCommit(timedOut);
        @(negedge clk);
        checks++;
        if (timedOut || barcos !== expB || frame_count !== CW'(1)) begin
            errors++; $display("[TB] FAIL reset_recover: got timeout=%b barcos=%h count=%0d expected 0 %h 1", timedOut, barcos, frame_count, expB);
        end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_abort();
        test_same_cycle_tick();
        test_flag_conflict();
        test_random_commits();
        test_blink_and_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
